nibble_serial_alu_ctrl: RTL
===========================

# nibble_serial_alu_ctrl

Multi-cycle add/subtract controller that time-shares one instance of the team's 4-bit ripple-carry adder (`_4bit_adder`) to add or subtract WIDTH-bit operands one nibble per cycle. It is the area-reduced arithmetic path for the MIPS datapath, used where a full-width adder is not justified. It latches operands on a start handshake and sequences nibbles LSB-first, chaining carry through a flop. It reports result, carry, signed overflow and zero with a one-cycle done pulse.

## Interface
- `WIDTH`, default 32: operand/result width; must be a multiple of 4 and at least 8.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = A+B, 1 = A−B; captured with operands.
- `a`  in  WIDTH  operand A; captured when start is accepted.
- `b`  in  WIDTH  operand B; captured when start is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse in DONE.
- `result`  out  WIDTH  sum/difference; valid from done until next accepted start.
- `cout`  out  1  carry out of MSB nibble (for sub: 1 = no borrow).
- `overflow`  out  1  signed overflow.
- `zero`  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE & start: latch a → opA, (sub ? ~b : b) → opB, carry flop ← sub, nibble index ← 0, clear result register; → RUN. IDLE & !start: hold.
- RUN: adder inputs are opA[4i+3:4i], opB[4i+3:4i] and the carry flop. Each cycle writes the adder sum to result[4i+3:4i], the adder cout to the carry flop, and increments i. When i == WIDTH/4−1, the write happens and the state moves to DONE.
- DONE: done = 1 for exactly one cycle → IDLE. cout = final carry flop. overflow = (opA[MSB] == opB[MSB]) && (result[MSB] != opA[MSB]), using the inverted B for sub. zero = ~|result.
- start in RUN or DONE is ignored and is not queued. The requester must re-assert start in IDLE.
- result, cout, overflow and zero hold their values in IDLE until the next accepted start, which clears them.
- Index counter width is clog2(WIDTH/4). No wrap occurs because the exit happens on the last nibble.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0, zero=0. State is IDLE and the index is 0.
- Reset asserted in any state aborts the operation. Outputs take reset values on that edge, and no done is produced.
- Start accepted at edge E0. busy is high for cycles E0..E(N−1), where N = WIDTH/4. Nibble i is written at edge E(i+1). done is high between EN and E(N+1).
- Latency from start to done is N cycles (8 for WIDTH=32). Throughput is one operation per N+2 cycles, minimum.
- Outputs are registered, except zero, overflow and cout, which are combinational from registers.

## Structure
- Shared package `alu_ctrl_pkg`: state enum (IDLE/RUN/DONE), NIBBLE constant = 4.
- A single `_4bit_adder` instance is the only sub-module. All sequencing and muxing stays in this block, and no second adder is used.

## Test plan
- WIDTH=32, a=0x0000000F, b=0x00000001, sub=0 → done exactly 8 cycles after the start edge; result=0x00000010, cout=0, overflow=0, zero=0.
- a=0xFFFFFFFF, b=0x00000001, sub=0 → result=0x00000000, cout=1, zero=1, overflow=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → result=0x80000000, overflow=1, cout=0. Then a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, overflow=1.
- a=5, b=7, sub=1 → result=0xFFFFFFFE, cout=0 (borrow), overflow=0. a=7, b=7, sub=1 → result=0, cout=1, zero=1.
- start held high continuously with changing a/b → only IDLE samples are accepted; each done is separated by N+2 cycles; results match the operands latched at acceptance.
- reset asserted at RUN cycle 3 → all outputs are 0 on the next edge and no done pulse appears. A fresh start of 1+1 → result=2 after 8 cycles.

Source files
------------

// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// rtl/nibble_serial_alu_ctrl_pkg.sv - shared types and constants for the nibble-serial add/sub controller
// Purpose: sequencer state encoding and the nibble width used by the controller.
// Ports: none (package).
package alu_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_alu_ctrl_if.sv
// rtl/nibble_serial_alu_ctrl_if.sv - request/response bundle for the nibble-serial add/sub controller
// Purpose: groups the start handshake, operands and result flags.
// Ports (master drives): start, sub, a, b.
// Ports (slave drives):  busy, done, result, cout, overflow, zero.
interface nibble_serial_alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/nibble_serial_alu_ctrl_adder.sv
// rtl/nibble_serial_alu_ctrl_adder.sv - 4-bit ripple-carry adder shared by the serial controller
// Purpose: one nibble of addition with carry in/out.
// Ports: a, b (4-bit addends), cin (carry in), sum (4-bit), cout (carry out).
module _4bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry;

    always_comb begin
        carry[0] = cin;
        for (int k = 0; k < 4; k++) begin
            sum[k]       = a[k] ^ b[k] ^ carry[k];
            carry[k + 1] = (a[k] & b[k]) | (carry[k] & (a[k] ^ b[k]));
        end
        cout = carry[4];
    end
endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// rtl/nibble_serial_alu_ctrl.sv - multi-cycle WIDTH-bit add/subtract using one shared 4-bit adder
// Purpose: latches operands on start, adds one nibble per cycle LSB-first with the carry
//          chained through a flop, then pulses done for one cycle.
// Ports: clk, reset (sync, active-high);
//        bus.start/sub/a/b in; bus.busy/done/result/cout/overflow/zero out.
module nibble_serial_alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    nibble_serial_alu_ctrl_if.slave  bus
);
    localparam int N    = WIDTH / NIBBLE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    // Set once the last nibble lands; keeps the flags at 0 after reset and
    // while an operation is still in flight.
    logic             valid_q, valid_d;

    logic [3:0] add_a, add_b, add_sum;
    logic       add_cout;

    _4bit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
                add_a = op_a_q[k*NIBBLE +: NIBBLE];
                add_b = op_b_q[k*NIBBLE +: NIBBLE];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        carry_d  = carry_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_a_d   = bus.a;
                    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                    op_b_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d  = bus.sub;
                    idx_d    = '0;
                    result_d = '0;
                    valid_d  = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        result_d[k*NIBBLE +: NIBBLE] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = valid_q & carry_q;
    assign bus.overflow = valid_q & (op_a_q[WIDTH-1] == op_b_q[WIDTH-1])
                                  & (result_q[WIDTH-1] != op_a_q[WIDTH-1]);
    assign bus.zero     = valid_q & ~|result_q;
endmodule
